spi_slave_gen2: RTL

Parametrised second-generation SPI slave that sits between an external SPI master and the single-port RAM. It deserialises command frames of (2 + DATA_WIDTH) bits into `rx_data`/`rx_valid` and serialises RAM read data from `tx_data`/`tx_valid` onto MISO. Over the first-generation slave it adds configurable payload width and bit order, read-address/read-data ordering enforcement, a RAM-response timeout, and an explicit frame-error report.

---
 rtl/spi_gen2_pkg.sv | 29 ++
 rtl/spi_gen2_shifter.sv | 39 +++
 rtl/spi_slave_gen2.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/spi_gen2_pkg.sv
// Shared types for the second-generation SPI slave.
//   state_t : frame FSM states
//   cmd_t   : two-bit command carried at the head of every frame
//   ERR_*   : err_code values reported alongside frame_err
package spi_gen2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_CMD,
    ST_CMD2,
    ST_RX_PAYLOAD,
    ST_WAIT_TX,
    ST_TX_SHIFT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ABORT   = 2'd1;
  localparam logic [1:0] ERR_ORDER   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/spi_gen2_shifter.sv
// Parallel-load / serial shift register with selectable bit order.
//   clk       : clock
//   load      : load load_data (wins over shift_en)
//   load_data : parallel load value
//   shift_en  : shift one bit, ser_in enters at the far end
//   ser_in    : serial input
//   ser_out   : bit currently at the output end (MSB or LSB per MSB_FIRST)
//   par_out   : current register contents
// Datapath only, so the register carries no reset.
module spi_gen2_shifter
  import spi_gen2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  input  logic                  ser_in,
  output logic                  ser_out,
  output logic [DATA_WIDTH-1:0] par_out
);

  logic [DATA_WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (load) begin
      sr_q <= load_data;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) sr_q <= {sr_q[DATA_WIDTH-2:0], ser_in};
      else                sr_q <= {ser_in, sr_q[DATA_WIDTH-1:1]};
    end
  end

  assign ser_out = (MSB_FIRST != 0) ? sr_q[DATA_WIDTH-1] : sr_q[0];
  assign par_out = sr_q;

endmodule

// File: rtl/spi_slave_gen2.sv
// Second-generation SPI slave in front of the single-port RAM.
//   clk, rst_n          : system/SPI bit clock, async active-low reset
//   SS_n, MOSI          : slave select (active low) and serial data in
//   MISO                : serial read data, 0 outside TX_SHIFT
//   rx_data, rx_valid   : received {cmd, payload} and its one-cycle strobe
//   tx_data, tx_valid   : RAM read data, captured only in WAIT_TX
//   frame_err, err_code : one-cycle drop report (abort / order / timeout)
//   busy                : FSM is not IDLE
module spi_slave_gen2
  import spi_gen2_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int MSB_FIRST    = 1,
  parameter int TX_TIMEOUT   = 16,
  parameter int STRICT_ORDER = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int TW = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);

  function automatic logic [CW-1:0] bit_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [TW-1:0] to_inc(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            cmd_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [TW-1:0]         to_cnt_q;
  logic                  pend_q, pend_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [DATA_WIDTH+1:0] rx_data_q;
  logic                  order_viol;

  logic [DATA_WIDTH-1:0] rx_par;
  logic                  rx_ser_unused;
  logic [DATA_WIDTH-1:0] tx_par_unused;
  logic                  tx_ser;
  logic                  tx_load;

  assign tx_load = (state_q == ST_WAIT_TX) && !SS_n && tx_valid;

  spi_gen2_shifter #(.DATA_WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST)) u_rx_shift (
    .clk       (clk),
    .load      (1'b0),
    .load_data ({DATA_WIDTH{1'b0}}),
    .shift_en  ((state_q == ST_RX_PAYLOAD) && !SS_n),
    .ser_in    (MOSI),
    .ser_out   (rx_ser_unused),
    .par_out   (rx_par)
  );

  spi_gen2_shifter #(.DATA_WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST)) u_tx_shift (
    .clk       (clk),
    .load      (tx_load),
    .load_data (tx_data),
    .shift_en  ((state_q == ST_TX_SHIFT) && !SS_n),
    .ser_in    (1'b0),
    .ser_out   (tx_ser),
    .par_out   (tx_par_unused)
  );

  // cmd_q is complete by the time the last payload bit arrives.
  assign order_viol = (STRICT_ORDER != 0) &&
                      (((cmd_q == CMD_RD_DATA) && !pend_q) ||
                       ((cmd_q == CMD_RD_ADDR) &&  pend_q));

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = ERR_NONE;
    if (SS_n) begin
      // Deselect ends any frame; a partially shifted one is reported as abort.
      state_d = ST_IDLE;
      if (state_q != ST_IDLE && state_q != ST_DONE) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_ABORT;
      end
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_CHK_CMD;
        ST_CHK_CMD: state_d = ST_CMD2;
        ST_CMD2:    state_d = ST_RX_PAYLOAD;
        ST_RX_PAYLOAD: begin
          if (bit_cnt_q == BIT_LAST) begin
            if (order_viol) begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_ORDER;
              state_d     = ST_DONE;
            end else begin
              rx_valid_d = 1'b1;
              if (cmd_q == CMD_RD_ADDR) pend_d = 1'b1;
              if (cmd_q == CMD_RD_DATA) pend_d = 1'b0;
              state_d = (cmd_q == CMD_RD_DATA) ? ST_WAIT_TX : ST_DONE;
            end
          end
        end
        ST_WAIT_TX: begin
          if (tx_valid) begin
            state_d = ST_TX_SHIFT;
          end else if ((TX_TIMEOUT > 0) && (to_cnt_q == TO_LAST)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_DONE;
          end
        end
        ST_TX_SHIFT: if (bit_cnt_q == BIT_LAST) state_d = ST_DONE;
        ST_DONE:     state_d = ST_DONE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 2'b00;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      pend_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      if (state_q == ST_CHK_CMD) cmd_q[1] <= MOSI;
      if (state_q == ST_CMD2)    cmd_q[0] <= MOSI;
      // Freeze the delivered frame so rx_data survives the next frame's shifting.
      if (rx_valid_q) rx_data_q <= {cmd_q, rx_par};
      if (state_d != state_q) bit_cnt_q <= '0;
      else if (state_q == ST_RX_PAYLOAD || state_q == ST_TX_SHIFT) bit_cnt_q <= bit_inc(bit_cnt_q);
      if (state_d != state_q) to_cnt_q <= '0;
      else if (state_q == ST_WAIT_TX) to_cnt_q <= to_inc(to_cnt_q);
    end
  end

  // In the strobe cycle the frame is presented straight from the rx shifter.
  assign rx_data   = rx_valid_q ? {cmd_q, rx_par} : rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);
  assign MISO      = (state_q == ST_TX_SHIFT) && tx_ser;

endmodule
